// File: rtl/round_robin_selector.sv
// ============================================================================
// round_robin_selector : 4-way round-robin select for a downstream 4:1 mux
// Revision 1.0
// ============================================================================
`default_nettype none

module round_robin_selector #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic advance,
  output logic address0,
  output logic address1,
  output logic valid,
  output logic timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit          TIMEOUT_EN = (MAX_HOLD != 0);
  localparam int unsigned HOLD_M1    = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0]  HOLD_LAST  = HOLD_M1[7:0];

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic [3:0]  req_vec;
  logic [2:0]  win_idle;
  logic [2:0]  win_rot;
  logic        hold_expired;

  // Returns {found, index}; the scan runs farthest-first so the nearest hit wins.
  function automatic logic [2:0] arbitrate(input logic [1:0] base, input logic [3:0] req);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req_vec      = {req3, req2, req1, req0};
  assign win_idle     = arbitrate(last_q, req_vec);
  assign win_rot      = arbitrate(addr_q, req_vec);
  assign hold_expired = TIMEOUT_EN && (hcnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    hcnt_d    = hcnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (win_idle[2]) begin
          state_d = GRANT;
          addr_d  = win_idle[1:0];
          valid_d = 1'b1;
          hcnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (advance || !req_vec[addr_q] || hold_expired) begin
          last_d = addr_q;
          hcnt_d = 8'd0;
          if (win_rot[2]) begin
            addr_d    = win_rot[1:0];
            valid_d   = 1'b1;
            // Only a pure hold expiry (no advance, requester still up) is a forced rotation.
            timeout_d = !advance && req_vec[addr_q];
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      addr_q    <= 2'd0;
      hcnt_q    <= 8'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      hcnt_q    <= hcnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign valid    = valid_q;
  assign timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_round_robin_selector.sv
// ============================================================================
// tb_round_robin_selector : directed checks of round_robin_selector
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_round_robin_selector;

  logic clk = 1'b0;
  logic reset;
  logic req0, req1, req2, req3;
  logic advance;
  logic a_addr0, a_addr1, a_valid, a_timeout;
  logic b_addr0, b_addr1, b_valid, b_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_robin_selector #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .advance(advance),
    .address0(a_addr0), .address1(a_addr1), .valid(a_valid), .timeout(a_timeout)
  );

  round_robin_selector #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2), .req3(req3),
    .advance(advance),
    .address0(b_addr0), .address1(b_addr1), .valid(b_valid), .timeout(b_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {req3, req2, req1, req0} = r;
  endtask

  // Expected vector layout: {valid, addr[1:0], timeout}
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed v/a/t=%b/%0d/%b expected v/a/t=%b/%0d/%b",
             tag, obs[3], obs[2:1], obs[0], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [1:0] a, input logic t);
    chk(tag, {a_valid, a_addr1, a_addr0, a_timeout}, {v, a, t});
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [1:0] a, input logic t);
    chk(tag, {b_valid, b_addr1, b_addr0, b_timeout}, {v, a, t});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; advance = 1'b1; set_req(4'b1111);

    // Reset held for several cycles keeps outputs at reset values
    step(); chk_a("reset_c1", 1'b0, 2'd0, 1'b0);
    step(); chk_a("reset_c2", 1'b0, 2'd0, 1'b0);
    chk_b("reset_b", 1'b0, 2'd0, 1'b0);

    // req=0101, advance held: 0,2,0,2 then withdrawal to IDLE
    reset = 1'b0; set_req(4'b0101); advance = 1'b1;
    step(); chk_a("alt_g0", 1'b1, 2'd0, 1'b0);
    step(); chk_a("alt_g1", 1'b1, 2'd2, 1'b0);
    step(); chk_a("alt_g2", 1'b1, 2'd0, 1'b0);
    step(); chk_a("alt_g3", 1'b1, 2'd2, 1'b0);
    set_req(4'b0000); advance = 1'b0;
    step(); chk_a("alt_idle", 1'b0, 2'd2, 1'b0);
    step(); chk_a("idle_stay", 1'b0, 2'd2, 1'b0);

    // req=1111 with advance every cycle: 0,1,2,3,0
    do_reset();
    set_req(4'b1111); advance = 1'b1;
    step(); chk_a("rr_0", 1'b1, 2'd0, 1'b0);
    step(); chk_a("rr_1", 1'b1, 2'd1, 1'b0);
    step(); chk_a("rr_2", 1'b1, 2'd2, 1'b0);
    step(); chk_a("rr_3", 1'b1, 2'd3, 1'b0);
    step(); chk_a("rr_wrap", 1'b1, 2'd0, 1'b0);

    // MAX_HOLD=4, req=0011, no advance: forced rotations with timeout pulse
    do_reset();
    set_req(4'b0011); advance = 1'b0;
    step(); chk_a("hold0_c0", 1'b1, 2'd0, 1'b0);
    step(); chk_a("hold0_c1", 1'b1, 2'd0, 1'b0);
    step(); chk_a("hold0_c2", 1'b1, 2'd0, 1'b0);
    step(); chk_a("hold0_c3", 1'b1, 2'd0, 1'b0);
    step(); chk_a("hold1_to", 1'b1, 2'd1, 1'b1);
    step(); chk_a("hold1_c1", 1'b1, 2'd1, 1'b0);
    step(); chk_a("hold1_c2", 1'b1, 2'd1, 1'b0);
    step(); chk_a("hold1_c3", 1'b1, 2'd1, 1'b0);
    step(); chk_a("hold_back0", 1'b1, 2'd0, 1'b1);

    // Withdrawal on index 2, then req0 rises
    do_reset();
    set_req(4'b0100);
    step(); chk_a("wd_g2", 1'b1, 2'd2, 1'b0);
    set_req(4'b0000);
    step(); chk_a("wd_idle", 1'b0, 2'd2, 1'b0);
    set_req(4'b0001);
    step(); chk_a("wd_g0", 1'b1, 2'd0, 1'b0);

    // Reset mid-grant on index 3
    do_reset();
    set_req(4'b1000);
    step(); chk_a("mr_g3", 1'b1, 2'd3, 1'b0);
    step(); chk_a("mr_hold", 1'b1, 2'd3, 1'b0);
    reset = 1'b1;
    step(); chk_a("mr_reset", 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    step(); chk_a("mr_regrant", 1'b1, 2'd3, 1'b0);

    // MAX_HOLD=1: advance beats timeout, then forced rotations
    do_reset();
    set_req(4'b0110); advance = 1'b0;
    step(); chk_b("mh1_g1", 1'b1, 2'd1, 1'b0);
    advance = 1'b1;
    step(); chk_b("mh1_adv_wins", 1'b1, 2'd2, 1'b0);
    advance = 1'b0;
    step(); chk_b("mh1_force", 1'b1, 2'd1, 1'b1);
    set_req(4'b0010);
    step(); chk_b("mh1_self", 1'b1, 2'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_robin_selector.md
ROUND_ROBIN_SELECTOR -- requirements
Module: round_robin_selector

Interface
REQ-001 Parameter MAX_HOLD, default 4, meaning: the maximum number of GRANT cycles without advance before a forced rotation; legal range 0..255, where 0 disables the timeout.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req0, req1, req2, req3  input  1 each  request lines; reqN high means source N has data on mux input inN.
REQ-005 advance  input  1  the consumer has taken the currently selected mux output this cycle.
REQ-006 address0, address1  output  1 each  the select lines driven to the downstream 4:1 mux; index = {address1, address0}.
REQ-007 valid  output  1  the mux output at the current index is a granted, valid selection.
REQ-008 timeout  output  1  one-cycle pulse marking a forced rotation.
REQ-009 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-010 The block SHALL hold a 2-state FSM (IDLE, GRANT), a 2-bit last-granted pointer "last", and an 8-bit hold counter "hcnt".
REQ-011 Arbitration SHALL scan indices last+1, last+2, last+3, last+4 (mod 4) and pick the first one whose req is high; all index arithmetic wraps modulo 4.
REQ-012 In IDLE with all req low, the block SHALL remain in IDLE: valid=0, address unchanged.
REQ-013 In IDLE with any req high at an edge, the block SHALL enter GRANT at that edge: address = arbitration winner, valid=1, hcnt=0; latency from req rising to valid = 1 cycle.
REQ-014 In GRANT, an edge with advance=1 SHALL set last to the current index, then re-arbitrate from the new last using req sampled at the same edge.
REQ-015 If that re-arbitration finds a requester, the block SHALL stay in GRANT with the new address, valid=1, hcnt=0.
REQ-016 If that re-arbitration finds no requester, the block SHALL go to IDLE with valid=0 and address held.
REQ-017 In GRANT, an edge with advance=0 and the granted req low SHALL be treated exactly as advance=1 (withdrawal): last updated, then re-arbitration.
REQ-018 In GRANT, an edge with advance=0 and the granted req high SHALL hold address and valid, and increment hcnt.
REQ-019 When MAX_HOLD is nonzero and hcnt equals MAX_HOLD-1 at a REQ-018 edge, the block SHALL force a rotation per REQ-014 instead of incrementing, and SHALL assert timeout for exactly that next cycle.
REQ-020 A forced rotation SHALL re-grant the same index if it is the only requester, and SHALL still pulse timeout in that case.
REQ-021 advance sampled while valid=0 SHALL be ignored.
REQ-022 Simultaneous advance and timeout condition: advance SHALL take precedence and timeout SHALL NOT pulse.
REQ-023 address0 and address1 SHALL change only at an edge where a new grant is issued or reset is applied; they SHALL never glitch during a held grant.
REQ-024 timeout SHALL be 0 on every cycle other than those given by REQ-019.

Reset
REQ-025 When reset=1 at an edge, the block SHALL set state=IDLE, valid=0, timeout=0, address0=0, address1=0, last=3, hcnt=0, regardless of all other inputs, including mid-GRANT.
REQ-026 On the first edge after reset deasserts, the block SHALL arbitrate normally; with last=3, index 0 has highest priority.
REQ-027 reset held for multiple cycles SHALL keep all outputs at their reset values.

Verification
REQ-028 Reset, then req=0101 and advance held 1 -> grant sequence 0,2,0,2 with valid=1 continuously, first valid one cycle after req rises.
REQ-029 req=1111 and advance pulsed each cycle -> address sequence 0,1,2,3,0 (wrap from 3 to 0 verified).
REQ-030 MAX_HOLD=4, req=0011, advance=0 -> index 0 held for 4 cycles, then index 1 with timeout=1 for one cycle, then index 1 held for 4 cycles.
REQ-031 Granted on index 2 with req=0100, req2 drops and advance=0 -> next edge valid=0, address stays 2, state IDLE; req0 then rises -> grant index 0.
REQ-032 reset=1 asserted mid-GRANT on index 3 -> next cycle valid=0, address=0, timeout=0; after release with req=1000 -> grant index 3.
REQ-033 advance and timeout coincide with MAX_HOLD=1 and req=0110 -> rotation to index 2 with timeout=0.
